fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of decode and immediate generation.
- Maintains the fetch PC and issues in-order word requests to the instruction memory port.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles control-flow redirects from execute: flushes buffered instructions and discards responses to in-flight requests.

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit_sync_fifo.sv | 64 ++++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types: word and instruction aliases plus the buffered fetch entry.
// Decode reuses fetch_entry_t, so keep the field order stable.
package fetch_unit_pkg;

    typedef logic [31:0] word;
    typedef logic [31:0] instr_t;

    localparam word DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        word    pc;
        instr_t inst;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

    function automatic word align_word(input word addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Generic synchronous FIFO with flush; head is a registered storage entry, valid one cycle after push.
// Push while full is accepted only together with a pop; flush empties it in one cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && full && !pop));

    count_range_chk: assert property (@(posedge clk) disable iff (rst)
        count <= CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: issues in-order word requests, buffers {pc, inst} for decode; decode sees a response one cycle later.
// Requests are credit-limited by buffer space, so memory responses never need backpressure.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter word RESET_PC   = DEFAULT_RESET_PC,
    parameter int  FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic         fetch_en;
    word          fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] pcq_count;
    logic [CW:0]   credit_used;
    logic          req_fire;
    logic          resp_keep;
    logic          dec_fire;
    word           pcq_head;
    logic          pcq_full;
    logic          pcq_empty;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  ent_in;
    fetch_entry_t  ent_head;

    // fetch_en holds requests off for the first cycle after reset.
    assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid = fetch_en && !redirect_valid && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_keep      = imem_resp_valid && (drop == '0);

    assign dec_valid = !fifo_empty;
    assign dec_fire  = dec_valid && dec_ready;
    assign dec_pc    = ent_head.pc;
    assign dec_inst  = ent_head.inst;

    assign ent_in = '{pc: pcq_head, inst: imem_resp_data};

    // The PC queue is never flushed: dropped responses still pop their entry.
    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (imem_resp_valid),
        .head      (pcq_head),
        .full      (pcq_full),
        .empty     (pcq_empty),
        .count     (pcq_count)
    );

    sync_fifo #(
        .WIDTH (FETCH_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (resp_keep && !redirect_valid),
        .push_data (ent_in),
        .pop       (dec_fire),
        .head      (ent_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_en    <= 1'b0;
            fetch_pc    <= align_word(RESET_PC);
            outstanding <= '0;
            drop        <= '0;
        end else begin
            fetch_en    <= 1'b1;
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= align_word(redirect_pc);
                drop     <= outstanding - CW'(imem_resp_valid);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (imem_resp_valid && (drop != '0)) begin
                    drop <= drop - 1'b1;
                end
            end
        end
    end

    resp_without_req_chk: assert property (@(posedge clk) disable iff (rst)
        !(imem_resp_valid && (outstanding == '0)));

    outstanding_range_chk: assert property (@(posedge clk) disable iff (rst)
        (outstanding <= CW'(FIFO_DEPTH)) && (drop <= outstanding) && (fifo_count <= CW'(FIFO_DEPTH)));

    pcq_tracks_outstanding_chk: assert property (@(posedge clk) disable iff (rst)
        (pcq_count == outstanding) && (pcq_empty == (outstanding == '0)) && !(req_fire && pcq_full));

    no_req_when_full_chk: assert property (@(posedge clk) disable iff (rst)
        !(fifo_full && imem_req_valid));

    req_stable_chk: assert property (@(posedge clk) disable iff (rst)
        (imem_req_valid && !imem_req_ready) |=>
            (redirect_valid || (imem_req_valid && (imem_req_addr == $past(imem_req_addr)))));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with programmable latency,
// expected-decode scoreboard, per-cycle vector table and directed redirect/reset sequences.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam word RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;

    fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_inst        (dec_inst),
        .dec_pc          (dec_pc)
    );

    always #5 clk = ~clk;

    typedef struct { word addr; int due; } mem_req_t;
    typedef struct { word pc; bit stale; } flight_t;
    typedef struct {
        bit  dec_ready;
        bit  req_ready;
        bit  exp_rv;
        word exp_addr;
        bit  exp_dv;
        word exp_dpc;
    } vec_t;

    mem_req_t memq[$];
    flight_t  inflight[$];
    word      expq[$];
    word      seen[$];
    vec_t     tbl[8];
    int       cycle;
    int       lat;
    int       n_tests;
    int       n_fail;
    word      exp_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Memory answers with the bitwise inverse of the address, exactly lat cycles after accept.
    task automatic drive_resp();
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (memq.size() > 0 && memq[0].due == cycle) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = ~memq[0].addr;
            void'(memq.pop_front());
        end
    endtask

    // Observe the current cycle, update the scoreboard, advance one clock.
    task automatic step();
        bit      req_fire;
        bit      dec_fire;
        word     e;
        flight_t f;
        #1;
        req_fire = imem_req_valid && imem_req_ready;
        dec_fire = dec_valid && dec_ready;
        if (dec_fire) begin
            seen.push_back(dec_pc);
            if (expq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL dec_unexpected: got pc %h, expected no transfer (cycle %0d)", dec_pc, cycle);
            end else begin
                e = expq.pop_front();
                check("dec_pc", dec_pc, e);
                check("dec_inst", dec_inst, ~e);
            end
        end
        if (redirect_valid) begin
            check("redirect_blocks_req", {31'b0, imem_req_valid}, 32'd0);
            expq.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            exp_pc = {redirect_pc[31:2], 2'b00};
        end
        if (imem_resp_valid && inflight.size() > 0) begin
            f = inflight.pop_front();
            if (!f.stale && !redirect_valid) expq.push_back(f.pc);
        end
        if (req_fire) begin
            check("req_addr", imem_req_addr, exp_pc);
            inflight.push_back('{pc: imem_req_addr, stale: 1'b0});
            memq.push_back('{addr: imem_req_addr, due: cycle + lat});
            exp_pc = exp_pc + 32'd4;
        end
        @(posedge clk);
        @(negedge clk);
        cycle++;
        drive_resp();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Called at time 0 or at a falling edge; returns in cycle 0 after reset.
    task automatic do_reset();
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b1;
        dec_ready       = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        memq.delete();
        inflight.delete();
        expq.delete();
        seen.delete();
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        cycle  = 0;
        exp_pc = RST_PC;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cycle   = 0;
        lat     = 1;
        // dec_ready, req_ready, exp req_valid, exp addr, exp dec_valid, exp dec_pc
        tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 32'h104};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h10C, 1'b0, 32'h0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h108};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h110, 1'b1, 32'h10C};

        // Reset state and streaming at latency 1
        do_reset();
        #1;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
        check("rst_dec_inst", dec_inst, 32'd0);
        check("rst_dec_pc", dec_pc, 32'd0);
        for (int i = 0; i < 8; i++) begin
            dec_ready      = tbl[i].dec_ready;
            imem_req_ready = tbl[i].req_ready;
            #1;
            check($sformatf("vec%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].exp_rv});
            if (tbl[i].exp_rv) check($sformatf("vec%0d_req_addr", i), imem_req_addr, tbl[i].exp_addr);
            check($sformatf("vec%0d_dec_valid", i), {31'b0, dec_valid}, {31'b0, tbl[i].exp_dv});
            if (tbl[i].exp_dv) check($sformatf("vec%0d_dec_pc", i), dec_pc, tbl[i].exp_dpc);
            step();
        end

        // Decode stalled: buffer fills, requests stop, head holds
        do_reset();
        dec_ready = 1'b0;
        run(6);
        #1;
        check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("stall_dec_valid", {31'b0, dec_valid}, 32'd1);
        check("stall_dec_pc", dec_pc, 32'h100);
        check("stall_dec_inst", dec_inst, ~32'h100);
        run(2);
        check("stall_hold_pc", dec_pc, 32'h100);
        dec_ready = 1'b1;
        step();
        #1;
        check("resume_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("resume_req_addr", imem_req_addr, 32'h108);
        run(8);

        // Reset while the buffer is full
        dec_ready = 1'b0;
        run(6);
        #1;
        check("prerst_full_dv", {31'b0, dec_valid}, 32'd1);
        check("prerst_full_rv", {31'b0, imem_req_valid}, 32'd0);
        do_reset();
        #1;
        check("midrst_dec_valid", {31'b0, dec_valid}, 32'd0);
        check("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        step();
        #1;
        check("midrst_restart_rv", {31'b0, imem_req_valid}, 32'd1);
        check("midrst_restart_addr", imem_req_addr, RST_PC);
        run(4);

        // Latency 3, two in flight, redirect to an unaligned target
        lat = 3;
        do_reset();
        run(3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2002;
        step();
        redirect_valid = 1'b0;
        seen.delete();
        run(12);
        check("redir_dec_count_ok", {31'b0, seen.size() > 0}, 32'd1);
        check("redir_first_dec_pc", (seen.size() > 0) ? seen[0] : 32'hFFFF_FFFF, 32'h2000);

        // Redirect coinciding with a kept response and a decode handshake
        lat = 1;
        do_reset();
        run(3);
        #1;
        check("coinc_setup_dv", {31'b0, dec_valid}, 32'd1);
        check("coinc_setup_resp", {31'b0, imem_resp_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000;
        step();
        redirect_valid = 1'b0;
        seen.delete();
        #1;
        check("coinc_flush_dv", {31'b0, dec_valid}, 32'd0);
        check("coinc_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("coinc_req_addr", imem_req_addr, 32'h3000);
        run(8);
        check("coinc_first_dec_pc", (seen.size() > 0) ? seen[0] : 32'hFFFF_FFFF, 32'h3000);

        // Memory not ready: request held stable, then wrap past the top of the address space
        do_reset();
        imem_req_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("hold%0d_req_valid", i), {31'b0, imem_req_valid}, 32'd1);
            check($sformatf("hold%0d_req_addr", i), imem_req_addr, 32'h100);
            step();
        end
        imem_req_ready = 1'b1;
        run(4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        seen.delete();
        run(10);
        check("wrap_dec0", (seen.size() > 0) ? seen[0] : 32'h1234_5678, 32'hFFFF_FFFC);
        check("wrap_dec1", (seen.size() > 1) ? seen[1] : 32'h1234_5678, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
